vga_sync_decoder: RTL and testbench
===================================

// Module: vga_sync_decoder
// PURPOSE
//  Receive side of the VGA timing interface: samples HSYNC/VSYNC from a VGA
//  timing generator, measures line/frame timing in clk cycles, and checks it against expected mode.
//  Raises locked after LOCK_FRAMES consecutive conforming frames. Used as loopback checker and input-mode detector.
// PARAMETERS
//  PERIOD_COUNT 4    clk cycles per pixel
//  H_TOTAL      800  pixels per line (active+porches+sync)
//  H_SYNC       96   hsync pulse width, pixels
//  V_TOTAL      525  lines per frame
//  V_SYNC       2    vsync pulse width, lines
//  TOL          2    allowed clk-cycle deviation on line period and hsync width
//  LOCK_FRAMES  2    consecutive good frames needed for lock (>=1)
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   async active-low reset
//  enable       in   1   count enable; low = all counters hold
//  hsync_in     in   1   horizontal sync, active low, asynchronous to clk
//  vsync_in     in   1   vertical sync, active low, asynchronous to clk
//  line_period  out  16  clk cycles between last two hsync falling edges
//  hsync_width  out  16  clk cycles hsync was low in last pulse
//  line_count   out  10  hsync falls in last complete frame
//  vsync_lines  out  10  hsync falls while vsync low in last vsync pulse
//  meas_valid   out  1   1-cycle pulse: frame measurement updated
//  locked       out  1   timing matches expected mode
//  sync_error   out  1   1-cycle pulse on loss of lock
// BEHAVIOUR
//  - reset_n low: all outputs 0; synchronizers/edge registers reset to 1; FSM=SEARCH; first-edge flags cleared.
//  - Inputs pass 2-FF synchronizer; edge detect on stage-2 vs registered copy. Pin edge -> detect 3 clk later.
//  - enable low: hcnt, lcnt, vl_cnt, FSM hold; sync/edge registers still update; edges in that time ignored.
//  - hcnt (16b, saturates at 0xFFFF): on hsync fall cycle line_period<=hcnt+1 (sat), hcnt<=0; else hcnt+1.
//    line_period only written after the second hsync fall since reset. On hsync rise hsync_width<=hcnt+1.
//  - Line check on each hsync fall (after first): |hcnt+1 - H_TOTAL*PERIOD_COUNT|>TOL or
//    |last hsync_width - H_SYNC*PERIOD_COUNT|>TOL sets sticky frame_bad.
//  - lcnt counts hsync falls; vl_cnt counts hsync falls while synchronized vsync low; vsync rise: vsync_lines<=vl_cnt, vl_cnt<=0.
//  - Vsync fall: first since reset only arms (lcnt<=0, frame_bad<=0, no pulse). Later ones: line_count<=lcnt,
//    frame evaluated, lcnt<=0, frame_bad<=0; meas_valid, locked, sync_error update next cycle.
//  - Simultaneous hsync fall and vsync fall: hsync fall counts in new frame (lcnt<=1); its line check applies to the new frame.
//  - frame_ok = !frame_bad && lcnt==V_TOTAL && vsync_lines==V_SYNC.
//  - FSM SEARCH/VERIFY/LOCKED, good_cnt:
//    SEARCH: frame_ok -> good_cnt=1; LOCKED if LOCK_FRAMES==1 else VERIFY.
//    VERIFY: frame_ok -> good_cnt+1, ==LOCK_FRAMES -> LOCKED; !frame_ok -> SEARCH, good_cnt=0.
//    LOCKED: !frame_ok -> SEARCH + sync_error pulse.
//  - Timeout: hcnt > 2*H_TOTAL*PERIOD_COUNT -> SEARCH, good_cnt=0; sync_error only if was LOCKED; frame_bad set.
//  - locked = (state==LOCKED), registered. Measurement outputs hold last value when no edges arrive.
//  - Reset mid-frame: immediate return to reset state; relock needs arming vsync + LOCK_FRAMES frames.
// TESTING
//  1 Drive nominal 640x480 (PERIOD 4): first vsync fall arms; frame1 end -> meas_valid, line_period=3200,
//    hsync_width=384, line_count=525, vsync_lines=2, locked=0; frame2 end -> locked=1.
//  2 Locked; one line period 3202 -> stays locked, no sync_error.
//  3 Locked; one line period 3203 -> at frame end sync_error 1 cycle, locked=0; two clean frames relock.
//  4 Locked; hold hsync_in high -> at hcnt=6401 locked=0, sync_error pulse; line_period stays 3200.
//  5 Frame of 524 lines -> meas_valid with line_count=524, FSM to SEARCH; vsync 3 lines -> vsync_lines=3, not ok.
//  6 reset_n low mid-frame -> outputs 0 at once; enable low 1000 cycles -> no pulses, counters frozen.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// VGA sync receiver. It samples HSYNC/VSYNC, measures line and frame timing
// in clk cycles, and locks once enough consecutive frames match the expected mode.
module vga_sync_decoder #(
  parameter int unsigned PERIOD_COUNT = 4,
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned TOL          = 2,
  parameter int unsigned LOCK_FRAMES  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [15:0] line_period,
  output logic [15:0] hsync_width,
  output logic [9:0]  line_count,
  output logic [9:0]  vsync_lines,
  output logic        meas_valid,
  output logic        locked,
  output logic        sync_error
);

  localparam int unsigned LINE_CLKS    = H_TOTAL * PERIOD_COUNT;
  localparam int unsigned HS_CLKS      = H_SYNC * PERIOD_COUNT;
  localparam int unsigned TIMEOUT_CLKS = 2 * LINE_CLKS;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic        hs_s1_q, hs_s2_q, hs_prev_q;
  logic        vs_s1_q, vs_s2_q, vs_prev_q;
  logic [15:0] hcnt_q, hcnt_d;
  logic [9:0]  lcnt_q, lcnt_d;
  logic [9:0]  vl_cnt_q, vl_cnt_d;
  logic [15:0] line_period_q, line_period_d;
  logic [15:0] hsync_width_q, hsync_width_d;
  logic [9:0]  line_count_q, line_count_d;
  logic [9:0]  vsync_lines_q, vsync_lines_d;
  logic        meas_valid_q, meas_valid_d;
  logic        locked_q, locked_d;
  logic        sync_error_q, sync_error_d;
  logic        frame_bad_q, frame_bad_d;
  logic        h_seen_q, h_seen_d;
  logic        v_armed_q, v_armed_d;
  logic [1:0]  state_q, state_d;
  logic [7:0]  good_q, good_d;

  logic        hs_fall, hs_rise, vs_fall, vs_rise;
  logic [15:0] hcnt_inc;
  logic [9:0]  lcnt_inc, vl_inc;
  logic [31:0] hp1, hw;
  logic        line_bad, timeout, frame_ok;

  // Edge strobes, qualified by enable so edges during hold are dropped
  assign hs_fall = enable & hs_prev_q & ~hs_s2_q;
  assign hs_rise = enable & ~hs_prev_q & hs_s2_q;
  assign vs_fall = enable & vs_prev_q & ~vs_s2_q;
  assign vs_rise = enable & ~vs_prev_q & vs_s2_q;

  // Saturating increments and timing checks
  assign hcnt_inc = (hcnt_q == 16'hFFFF) ? hcnt_q : hcnt_q + 16'd1;
  assign lcnt_inc = (lcnt_q == 10'h3FF) ? lcnt_q : lcnt_q + 10'd1;
  assign vl_inc   = (vl_cnt_q == 10'h3FF) ? vl_cnt_q : vl_cnt_q + 10'd1;
  assign hp1      = 32'(hcnt_inc);
  assign hw       = 32'(hsync_width_q);
  assign line_bad = (hp1 > LINE_CLKS + TOL) || (hp1 + TOL < LINE_CLKS) ||
                    (hw > HS_CLKS + TOL) || (hw + TOL < HS_CLKS);
  assign timeout  = enable && (32'(hcnt_q) > TIMEOUT_CLKS);
  assign frame_ok = !frame_bad_q && (lcnt_q == 10'(V_TOTAL)) &&
                    (vsync_lines_q == 10'(V_SYNC));

  // Next-state: counters, measurements, frame evaluation and lock FSM
  always_comb begin
    hcnt_d        = hcnt_q;
    lcnt_d        = lcnt_q;
    vl_cnt_d      = vl_cnt_q;
    line_period_d = line_period_q;
    hsync_width_d = hsync_width_q;
    line_count_d  = line_count_q;
    vsync_lines_d = vsync_lines_q;
    meas_valid_d  = 1'b0;
    sync_error_d  = 1'b0;
    frame_bad_d   = frame_bad_q;
    h_seen_d      = h_seen_q;
    v_armed_d     = v_armed_q;
    state_d       = state_q;
    good_d        = good_q;

    if (enable) begin
      hcnt_d = hcnt_inc;
      if (hs_fall) begin
        hcnt_d   = 16'd0;
        h_seen_d = 1'b1;
        lcnt_d   = lcnt_inc;
        if (h_seen_q) begin
          line_period_d = hcnt_inc;
          if (line_bad) frame_bad_d = 1'b1;
        end
        if (!vs_s2_q) vl_cnt_d = vl_inc;
      end
      if (hs_rise) hsync_width_d = hcnt_inc;
      if (vs_rise) begin
        vsync_lines_d = vl_cnt_q;
        vl_cnt_d      = 10'd0;
      end
      if (vs_fall) begin
        // A coincident hsync fall opens the new frame and is checked there
        lcnt_d      = hs_fall ? 10'd1 : 10'd0;
        frame_bad_d = hs_fall && h_seen_q && line_bad;
        v_armed_d   = 1'b1;
        if (v_armed_q) begin
          line_count_d = lcnt_q;
          meas_valid_d = 1'b1;
          case (state_q)
            ST_SEARCH: if (frame_ok) begin
              good_d  = 8'd1;
              state_d = (LOCK_FRAMES == 1) ? ST_LOCKED : ST_VERIFY;
            end
            ST_VERIFY: if (frame_ok) begin
              good_d = good_q + 8'd1;
              if (32'(good_q) + 32'd1 == LOCK_FRAMES) state_d = ST_LOCKED;
            end else begin
              good_d  = 8'd0;
              state_d = ST_SEARCH;
            end
            ST_LOCKED: if (!frame_ok) begin
              good_d       = 8'd0;
              state_d      = ST_SEARCH;
              sync_error_d = 1'b1;
            end
            default: begin
              good_d  = 8'd0;
              state_d = ST_SEARCH;
            end
          endcase
        end
      end
      // Missing hsync: drop lock and spoil the current frame
      if (timeout) begin
        frame_bad_d = 1'b1;
        if (state_q == ST_LOCKED) sync_error_d = 1'b1;
        state_d = ST_SEARCH;
        good_d  = 8'd0;
      end
    end
    locked_d = (state_d == ST_LOCKED);
  end

  // State registers; synchronizers idle high
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_s1_q       <= 1'b1;
      hs_s2_q       <= 1'b1;
      hs_prev_q     <= 1'b1;
      vs_s1_q       <= 1'b1;
      vs_s2_q       <= 1'b1;
      vs_prev_q     <= 1'b1;
      hcnt_q        <= 16'd0;
      lcnt_q        <= 10'd0;
      vl_cnt_q      <= 10'd0;
      line_period_q <= 16'd0;
      hsync_width_q <= 16'd0;
      line_count_q  <= 10'd0;
      vsync_lines_q <= 10'd0;
      meas_valid_q  <= 1'b0;
      locked_q      <= 1'b0;
      sync_error_q  <= 1'b0;
      frame_bad_q   <= 1'b0;
      h_seen_q      <= 1'b0;
      v_armed_q     <= 1'b0;
      state_q       <= ST_SEARCH;
      good_q        <= 8'd0;
    end else begin
      hs_s1_q       <= hsync_in;
      hs_s2_q       <= hs_s1_q;
      hs_prev_q     <= hs_s2_q;
      vs_s1_q       <= vsync_in;
      vs_s2_q       <= vs_s1_q;
      vs_prev_q     <= vs_s2_q;
      hcnt_q        <= hcnt_d;
      lcnt_q        <= lcnt_d;
      vl_cnt_q      <= vl_cnt_d;
      line_period_q <= line_period_d;
      hsync_width_q <= hsync_width_d;
      line_count_q  <= line_count_d;
      vsync_lines_q <= vsync_lines_d;
      meas_valid_q  <= meas_valid_d;
      locked_q      <= locked_d;
      sync_error_q  <= sync_error_d;
      frame_bad_q   <= frame_bad_d;
      h_seen_q      <= h_seen_d;
      v_armed_q     <= v_armed_d;
      state_q       <= state_d;
      good_q        <= good_d;
    end
  end

  assign line_period = line_period_q;
  assign hsync_width = hsync_width_q;
  assign line_count  = line_count_q;
  assign vsync_lines = vsync_lines_q;
  assign meas_valid  = meas_valid_q;
  assign locked      = locked_q;
  assign sync_error  = sync_error_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down mode:
// 40-clk lines, 6-clk hsync, 10-line frames, 2-line vsync, TOL 2, lock after 2 frames.
module tb_vga_sync_decoder;

  localparam int PC   = 1;
  localparam int HT   = 40;
  localparam int HS   = 6;
  localparam int VT   = 10;
  localparam int VS   = 2;
  localparam int TOLV = 2;
  localparam int LF   = 2;
  localparam int LINE = HT * PC;
  localparam int HSW  = HS * PC;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        hsync_in;
  logic        vsync_in;
  logic [15:0] line_period;
  logic [15:0] hsync_width;
  logic [9:0]  line_count;
  logic [9:0]  vsync_lines;
  logic        meas_valid;
  logic        locked;
  logic        sync_error;

  int errors = 0;
  int checks = 0;

  int          mv_cnt = 0;
  int          se_cnt = 0;
  logic [9:0]  cap_lc = '0;
  logic [9:0]  cap_vl = '0;
  logic        cap_locked = 1'b0;

  vga_sync_decoder #(
    .PERIOD_COUNT(PC), .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT),
    .V_SYNC(VS), .TOL(TOLV), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .line_period(line_period), .hsync_width(hsync_width),
    .line_count(line_count), .vsync_lines(vsync_lines),
    .meas_valid(meas_valid), .locked(locked), .sync_error(sync_error)
  );

  always #5 clk = ~clk;

  // Pulse counters and frame-report capture
  always @(negedge clk) begin
    if (meas_valid === 1'b1) begin
      mv_cnt++;
      cap_lc     = line_count;
      cap_vl     = vsync_lines;
      cap_locked = locked;
    end
    if (sync_error === 1'b1) se_cnt++;
  end

  task automatic drive_line(input int period, input int width, input logic vs);
    hsync_in = 1'b0;
    vsync_in = vs;
    repeat (width) @(negedge clk);
    hsync_in = 1'b1;
    repeat (period - width) @(negedge clk);
  endtask

  task automatic drive_lines(input int first, input int last, input int vs_lines,
                             input int bad_idx, input int bad_period);
    for (int l = first; l <= last; l++)
      drive_line((l == bad_idx) ? bad_period : LINE, HSW, (l < vs_lines) ? 1'b0 : 1'b1);
  endtask

  task automatic test_reset();
    checks++;
    if ({line_period, hsync_width, line_count, vsync_lines, meas_valid, locked, sync_error} !== 55'd0) begin
      errors++;
      $display("FAIL reset_outputs: got lp=%0d hw=%0d lc=%0d vl=%0d mv=%b lk=%b se=%b want all 0",
               line_period, hsync_width, line_count, vsync_lines, meas_valid, locked, sync_error);
    end
  endtask

  task automatic test_nominal();
    int mv0;
    mv0 = mv_cnt;
    drive_line(LINE, HSW, 1'b0);
    checks++;
    if (line_period !== 16'd0) begin errors++; $display("FAIL first_fall_period: got %0d want 0", line_period); end
    checks++;
    if (hsync_width !== 16'(HSW)) begin errors++; $display("FAIL first_hsync_width: got %0d want %0d", hsync_width, HSW); end
    drive_lines(1, VT - 1, VS, -1, 0);
    checks++;
    if (mv_cnt !== mv0) begin errors++; $display("FAIL arm_no_pulse: got %0d pulses want 0", mv_cnt - mv0); end
    checks++;
    if (line_period !== 16'(LINE)) begin errors++; $display("FAIL nominal_period: got %0d want %0d", line_period, LINE); end
    drive_lines(0, VT - 1, VS, -1, 0);
    checks++;
    if (mv_cnt !== mv0 + 1) begin errors++; $display("FAIL frame1_pulse: got %0d want %0d", mv_cnt - mv0, 1); end
    checks++;
    if (cap_lc !== 10'(VT)) begin errors++; $display("FAIL frame1_line_count: got %0d want %0d", cap_lc, VT); end
    checks++;
    if (cap_vl !== 10'(VS)) begin errors++; $display("FAIL frame1_vsync_lines: got %0d want %0d", cap_vl, VS); end
    checks++;
    if (cap_locked !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL frame1_locked: got %b/%b want 0", cap_locked, locked); end
    drive_lines(0, VT - 1, VS, -1, 0);
    checks++;
    if (mv_cnt !== mv0 + 2) begin errors++; $display("FAIL frame2_pulse: got %0d want %0d", mv_cnt - mv0, 2); end
    checks++;
    if (cap_locked !== 1'b1 || locked !== 1'b1) begin errors++; $display("FAIL frame2_locked: got %b/%b want 1", cap_locked, locked); end
  endtask

  task automatic test_tolerance();
    int se0;
    se0 = se_cnt;
    drive_lines(0, 5, VS, 4, LINE + 2);
    checks++;
    if (line_period !== 16'(LINE + 2)) begin errors++; $display("FAIL tol_period: got %0d want %0d", line_period, LINE + 2); end
    drive_lines(6, VT - 1, VS, -1, 0);
    drive_lines(0, VT - 1, VS, -1, 0);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL tol_locked: got %b want 1", locked); end
    checks++;
    if (se_cnt !== se0) begin errors++; $display("FAIL tol_no_error: got %0d pulses want 0", se_cnt - se0); end
  endtask

  task automatic test_bad_line();
    int se0;
    se0 = se_cnt;
    drive_lines(0, VT - 1, VS, 4, LINE + 3);
    checks++;
    if (locked !== 1'b1 || se_cnt !== se0) begin errors++; $display("FAIL bad_before_eval: got lk=%b se=%0d want 1/0", locked, se_cnt - se0); end
    drive_lines(0, VT - 1, VS, -1, 0);
    checks++;
    if (se_cnt !== se0 + 1) begin errors++; $display("FAIL bad_sync_error: got %0d pulses want 1", se_cnt - se0); end
    checks++;
    if (locked !== 1'b0 || cap_locked !== 1'b0) begin errors++; $display("FAIL bad_unlock: got %b/%b want 0", locked, cap_locked); end
    drive_lines(0, VT - 1, VS, -1, 0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL relock_early: got %b want 0", locked); end
    drive_lines(0, VT - 1, VS, -1, 0);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL relock: got %b want 1", locked); end
  endtask

  task automatic test_timeout();
    int se0;
    se0 = se_cnt;
    hsync_in = 1'b1;
    repeat (30) @(negedge clk);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL timeout_early: got %b want 1", locked); end
    repeat (60) @(negedge clk);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL timeout_unlock: got %b want 0", locked); end
    checks++;
    if (se_cnt !== se0 + 1) begin errors++; $display("FAIL timeout_error: got %0d pulses want 1", se_cnt - se0); end
    checks++;
    if (line_period !== 16'(LINE)) begin errors++; $display("FAIL timeout_period_hold: got %0d want %0d", line_period, LINE); end
  endtask

  task automatic test_short_frame();
    drive_lines(0, VT - 1, VS, -1, 0);
    drive_lines(0, VT - 2, VS, -1, 0);
    drive_lines(0, VT - 1, VS, -1, 0);
    checks++;
    if (cap_lc !== 10'(VT - 1)) begin errors++; $display("FAIL short_line_count: got %0d want %0d", cap_lc, VT - 1); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL short_not_locked: got %b want 0", locked); end
    drive_lines(0, VT - 1, VS + 1, -1, 0);
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL short_rejected: got %b want 0", locked); end
    drive_lines(0, VT - 1, VS, -1, 0);
    checks++;
    if (cap_vl !== 10'(VS + 1)) begin errors++; $display("FAIL long_vsync_lines: got %0d want %0d", cap_vl, VS + 1); end
    checks++;
    if (cap_lc !== 10'(VT)) begin errors++; $display("FAIL long_vsync_line_count: got %0d want %0d", cap_lc, VT); end
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL long_vsync_rejected: got %b want 0", locked); end
  endtask

  task automatic test_enable_hold();
    int mv0, se0;
    logic [15:0] lp0, hw0;
    logic [9:0]  lc0, vl0;
    mv0 = mv_cnt; se0 = se_cnt;
    lp0 = line_period; hw0 = hsync_width; lc0 = line_count; vl0 = vsync_lines;
    enable = 1'b0;
    for (int i = 0; i < 33; i++) drive_line(30, 10, ((i % 4) < 2) ? 1'b0 : 1'b1);
    checks++;
    if (mv_cnt !== mv0 || se_cnt !== se0) begin errors++; $display("FAIL hold_pulses: got mv=%0d se=%0d want 0/0", mv_cnt - mv0, se_cnt - se0); end
    checks++;
    if (line_period !== lp0 || line_period !== 16'(LINE)) begin errors++; $display("FAIL hold_period: got %0d want %0d", line_period, LINE); end
    checks++;
    if (hsync_width !== hw0 || hsync_width !== 16'(HSW)) begin errors++; $display("FAIL hold_width: got %0d want %0d", hsync_width, HSW); end
    checks++;
    if (line_count !== lc0 || vsync_lines !== vl0) begin errors++; $display("FAIL hold_counts: got lc=%0d vl=%0d want %0d/%0d", line_count, vsync_lines, lc0, vl0); end
    enable = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int mv0;
    drive_lines(0, VT - 1, VS, -1, 0);
    drive_lines(0, VT - 1, VS, -1, 0);
    drive_lines(0, 4, VS, -1, 0);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({line_period, hsync_width, line_count, vsync_lines, meas_valid, locked, sync_error} !== 55'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got lp=%0d hw=%0d lc=%0d vl=%0d mv=%b lk=%b se=%b want all 0",
               line_period, hsync_width, line_count, vsync_lines, meas_valid, locked, sync_error);
    end
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mv0 = mv_cnt;
    drive_lines(0, VT - 1, VS, -1, 0);
    checks++;
    if (mv_cnt !== mv0) begin errors++; $display("FAIL rearm_no_pulse: got %0d want 0", mv_cnt - mv0); end
    drive_lines(0, VT - 1, VS, -1, 0);
    checks++;
    if (mv_cnt !== mv0 + 1 || locked !== 1'b0) begin errors++; $display("FAIL rearm_frame1: got mv=%0d lk=%b want 1/0", mv_cnt - mv0, locked); end
    drive_lines(0, VT - 1, VS, -1, 0);
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL rearm_lock: got %b want 1", locked); end
  endtask

  initial begin
    reset_n  = 1'b0;
    enable   = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    reset_n = 1'b1;
    @(negedge clk);
    test_nominal();
    test_tolerance();
    test_bad_line();
    test_timeout();
    test_short_frame();
    test_enable_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
